// File: rtl/lsu_mem_port.sv
// Load/store unit driving a single-port, word-wide data RAM.
// Sub-word stores use read-modify-write. Loads return extended data on a one-cycle strobe.
module lsu_mem_port #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [31:0]       mem_rd
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * MEM_WORDS);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              req_ready_d, rsp_valid_d, rsp_err_d, mem_we_d;
    logic [31:0]       rsp_rdata_d, mem_wd_d;
    logic [ADDR_W-1:0] mem_a_d;
    logic              acc_err_c;

    // Pick the lane out of a RAM word and sign/zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay right-aligned store data onto the word read back from RAM.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: r[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (lane[1]) r[31:16] = wdata[15:0];
                else         r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Request legality, evaluated on the live request at accept.
    always_comb begin
        acc_err_c = 1'b0;
        case (req_size)
            SZ_HALF: acc_err_c = req_addr[0];
            SZ_WORD: acc_err_c = |req_addr[1:0];
            2'b11:   acc_err_c = 1'b1;
            default: acc_err_c = 1'b0;
        endcase
        if (req_addr >= ADDR_LIMIT) acc_err_c = 1'b1;
    end

    // Next state plus next value of every registered output.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        mem_we_d    = 1'b0;
        mem_wd_d    = 32'h0;
        mem_a_d     = '0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (acc_err_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d  = WR;
                        mem_we_d = 1'b1;
                        mem_wd_d = req_wdata;
                        mem_a_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    end else begin
                        state_d = RD;
                        mem_a_d = {req_addr[ADDR_W-1:2], 2'b00};
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            RD: begin
                if (we_q) begin
                    state_d  = WR;
                    mem_we_d = 1'b1;
                    mem_wd_d = store_merge(mem_rd, wdata_q, size_q, addr_q[1:0]);
                    mem_a_d  = {addr_q[ADDR_W-1:2], 2'b00};
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_extract(mem_rd, size_q, addr_q[1:0], uns_q);
                end
            end
            WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request fields and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            mem_we    <= 1'b0;
            mem_wd    <= 32'h0;
            mem_a     <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            mem_we    <= mem_we_d;
            mem_wd    <= mem_wd_d;
            mem_a     <= mem_a_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: RAM model plus expected-response queue.
module tb_lsu_mem_port;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, mem_we;
    logic [31:0] rsp_rdata, mem_wd, mem_a, mem_rd;

    logic [31:0] ram [64];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    lsu_mem_port dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_we(mem_we), .mem_wd(mem_wd), .mem_a(mem_a),
        .mem_rd(mem_rd)
    );

    always #5 CLK = ~CLK;

    assign mem_rd = ram[mem_a[7:2]];
    always @(posedge CLK) if (mem_we) ram[mem_a[7:2]] = mem_wd;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request, wait for its response; returns what was observed.
    task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic r_err, output logic [31:0] r_data, output int lat,
                        output logic saw_we, output logic [31:0] we_a, output logic [31:0] we_d,
                        output logic twice);
        r_err = 0; r_data = 0; lat = -1; saw_we = 0; we_a = 0; we_d = 0; twice = 0;
        @(negedge CLK);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge CLK);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
        req_we = 1'($urandom); req_unsigned = 1'($urandom);
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            if (mem_we) begin saw_we = 1; we_a = mem_a; we_d = mem_wd; end
            if (rsp_valid) begin r_err = rsp_err; r_data = rsp_rdata; lat = n; break; end
        end
        if (lat > 0) begin
            @(negedge CLK);
            twice = rsp_valid;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b0 || rsp_rdata !== 0 || mem_a !== 0 || mem_wd !== 0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b err=%b we=%b rdata=%h a=%h wd=%h, want all 0",
                     req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_a, mem_wd);
        end
        RST_N = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", req_ready);
        end
        @(negedge CLK);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b want 1", req_ready);
        end
    endtask

    task automatic test_word();
        logic e_err, sw, tw; logic [31:0] d, a, wd; int lat; exp_t e;
        sbq.push_back('{1'b0, 32'h0, 2});
        xfer(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, e_err, d, lat, sw, a, wd, tw);
        e = sbq.pop_front();
        checks++;
        if (e_err !== e.err || d !== e.rdata || lat !== e.lat || tw !== 0 ||
            sw !== 1 || a !== 32'h10 || wd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_0x10: err=%b rdata=%h lat=%0d twice=%b we=%b a=%h wd=%h, want err=0 rdata=0 lat=2 we=1 a=10 wd=deadbeef",
                     e_err, d, lat, tw, sw, a, wd);
        end
        checks++;
        if (ram[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_ram: got %h want deadbeef", ram[4]);
        end
        sbq.push_back('{1'b0, 32'hDEADBEEF, 2});
        xfer(0, 2'b10, 0, 32'h10, 32'h0, e_err, d, lat, sw, a, wd, tw);
        e = sbq.pop_front();
        checks++;
        if (e_err !== e.err || d !== e.rdata || lat !== e.lat || tw !== 0 || sw !== 0) begin
            errors++;
            $display("FAIL lw_0x10: err=%b rdata=%h lat=%0d twice=%b we=%b, want err=0 rdata=%h lat=%0d no write",
                     e_err, d, lat, tw, sw, e.rdata, e.lat);
        end
    endtask

    task automatic test_subword_store();
        logic [1:0]  sz [5] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
        logic [31:0] ad [5] = '{32'h22, 32'h20, 32'h22, 32'h23, 32'h20};
        logic [31:0] wv [5] = '{32'h000000AA, 32'h0000BEEF, 32'hFFFF1234, 32'hABCDEF99, 32'h0};
        logic [31:0] ew [5] = '{32'h11AA3344, 32'h11AABEEF, 32'h1234BEEF, 32'h9934BEEF, 32'h0};
        logic e_err, sw, tw; logic [31:0] d, a, wd; int lat; exp_t e;
        ram[8] = 32'h11223344;
        for (int i = 0; i < 5; i++) begin
            logic st;
            st = (i < 4);
            sbq.push_back('{1'b0, st ? 32'h0 : 32'h9934BEEF, st ? 3 : 2});
            xfer(st, sz[i], 0, ad[i], wv[i], e_err, d, lat, sw, a, wd, tw);
            e = sbq.pop_front();
            checks++;
            if (e_err !== e.err || d !== e.rdata || lat !== e.lat || tw !== 0 || sw !== st ||
                (st && (a !== 32'h20 || wd !== ew[i]))) begin
                errors++;
                $display("FAIL subword[%0d]: err=%b rdata=%h lat=%0d twice=%b we=%b a=%h wd=%h, want rdata=%h lat=%0d we=%b a=20 wd=%h",
                         i, e_err, d, lat, tw, sw, a, wd, e.rdata, e.lat, st, ew[i]);
            end
        end
    endtask

    task automatic test_loads();
        logic [1:0]  sz [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
        logic        un [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        logic [31:0] ad [8] = '{32'h2, 32'h2, 32'h2, 32'h0, 32'h3, 32'h1, 32'h0, 32'h2};
        logic [31:0] ev [8] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01,
                                32'hFFFFFF80, 32'h0000007F, 32'h00007F01, 32'h000080FF};
        logic e_err, sw, tw; logic [31:0] d, a, wd; int lat; exp_t e;
        ram[0] = 32'h80FF7F01;
        for (int i = 0; i < 8; i++) begin
            sbq.push_back('{1'b0, ev[i], 2});
            xfer(0, sz[i], un[i], ad[i], 32'hFFFFFFFF, e_err, d, lat, sw, a, wd, tw);
            e = sbq.pop_front();
            checks++;
            if (e_err !== e.err || d !== e.rdata || lat !== e.lat || tw !== 0 || sw !== 0) begin
                errors++;
                $display("FAIL load[%0d]: err=%b rdata=%h lat=%0d twice=%b we=%b, want err=0 rdata=%h lat=2",
                         i, e_err, d, lat, tw, sw, e.rdata);
            end
        end
    endtask

    task automatic test_errors();
        logic        wv [7] = '{0, 1, 0, 0, 1, 1, 0};
        logic [1:0]  sz [7] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00};
        logic [31:0] ad [7] = '{32'h5, 32'h6, 32'h0, 32'h100, 32'h100, 32'h3, 32'hFFFFFFFC};
        logic e_err, sw, tw; logic [31:0] d, a, wd; int lat; exp_t e;
        ram[0] = 32'h80FF7F01;
        ram[1] = 32'h5A5A5A5A;
        for (int i = 0; i < 7; i++) begin
            sbq.push_back('{1'b1, 32'h0, 1});
            xfer(wv[i], sz[i], 0, ad[i], 32'h01020304, e_err, d, lat, sw, a, wd, tw);
            e = sbq.pop_front();
            checks++;
            if (e_err !== e.err || d !== e.rdata || lat !== e.lat || tw !== 0 || sw !== 0) begin
                errors++;
                $display("FAIL error[%0d]: err=%b rdata=%h lat=%0d twice=%b we=%b, want err=1 rdata=0 lat=1 no write",
                         i, e_err, d, lat, tw, sw);
            end
        end
        checks++;
        if (ram[0] !== 32'h80FF7F01 || ram[1] !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL error_ram: ram0=%h ram1=%h want 80ff7f01 5a5a5a5a", ram[0], ram[1]);
        end
        sbq.push_back('{1'b0, 32'h0, 2});
        xfer(1, 2'b10, 0, 32'hFC, 32'h12345678, e_err, d, lat, sw, a, wd, tw);
        e = sbq.pop_front();
        checks++;
        if (e_err !== e.err || lat !== e.lat || sw !== 1 || a !== 32'hFC || wd !== 32'h12345678) begin
            errors++;
            $display("FAIL sw_top: err=%b lat=%0d we=%b a=%h wd=%h, want err=0 lat=2 we=1 a=fc wd=12345678",
                     e_err, lat, sw, a, wd);
        end
        sbq.push_back('{1'b0, 32'h12345678, 2});
        xfer(0, 2'b10, 0, 32'hFC, 32'h0, e_err, d, lat, sw, a, wd, tw);
        e = sbq.pop_front();
        checks++;
        if (e_err !== e.err || d !== e.rdata || lat !== e.lat || ram[0] !== 32'h80FF7F01) begin
            errors++;
            $display("FAIL lw_top: err=%b rdata=%h lat=%0d ram0=%h, want err=0 rdata=12345678 lat=2 ram0=80ff7f01",
                     e_err, d, lat, ram[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic        bwe [3] = '{1, 0, 1};
        logic [1:0]  bsz [3] = '{2'b10, 2'b10, 2'b00};
        logic [31:0] bad [3] = '{32'h30, 32'h30, 32'h31};
        logic [31:0] bwd [3] = '{32'hCAFEF00D, 32'h0, 32'h00000055};
        logic [31:0] brd [3] = '{32'h0, 32'hCAFEF00D, 32'h0};
        int idx = 0, acc = 0, rsp_n = 0, viol = 0;
        logic acc_now;
        exp_t e;
        @(negedge CLK);
        req_we = bwe[0]; req_size = bsz[0]; req_unsigned = 0; req_addr = bad[0]; req_wdata = bwd[0];
        req_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_rsp: response %0d with nothing outstanding", rsp_n);
                end else begin
                    e = sbq.pop_front();
                    if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL b2b_rsp[%0d]: err=%b rdata=%h, want err=%b rdata=%h",
                                 rsp_n, rsp_err, rsp_rdata, e.err, e.rdata);
                    end
                end
                rsp_n++;
            end
            if (req_ready && (mem_we || rsp_valid || mem_a != 0)) viol++;
            acc_now = req_valid && req_ready;
            @(posedge CLK);
            if (acc_now) begin
                sbq.push_back('{1'b0, brd[idx], 0});
                acc++;
                idx++;
                #1;
                if (idx < 3) begin
                    req_we = bwe[idx]; req_size = bsz[idx]; req_addr = bad[idx]; req_wdata = bwd[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge CLK);
        end
        req_valid = 1'b0;
        checks++;
        if (acc !== 3 || rsp_n !== 3 || viol !== 0) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d responses=%0d busy_ready=%0d, want 3 3 0", acc, rsp_n, viol);
        end
        checks++;
        if (ram[12] !== 32'hCAFE550D) begin
            errors++;
            $display("FAIL b2b_ram: got %h want cafe550d", ram[12]);
        end
        sbq.delete();
    endtask

    task automatic test_reset_mid();
        logic e_err, sw, tw; logic [31:0] d, a, wd; int lat; exp_t e;
        ram[16] = 32'h0BADF00D;
        @(negedge CLK);
        req_we = 1; req_size = 2'b00; req_unsigned = 0; req_addr = 32'h41; req_wdata = 32'h77;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge CLK);
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (mem_we !== 1'b1 || mem_wd !== 32'h0BAD770D) begin
            errors++;
            $display("FAIL mid_wr_phase: we=%b wd=%h, want we=1 wd=0bad770d", mem_we, mem_wd);
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: we=%b valid=%b ready=%b, want 0 0 0", mem_we, rsp_valid, req_ready);
        end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        checks++;
        if (ram[16] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL mid_reset_ram: got %h want 0badf00d", ram[16]);
        end
        sbq.push_back('{1'b0, 32'h0BADF00D, 2});
        xfer(0, 2'b10, 0, 32'h40, 32'h0, e_err, d, lat, sw, a, wd, tw);
        e = sbq.pop_front();
        checks++;
        if (e_err !== e.err || d !== e.rdata || lat !== e.lat) begin
            errors++;
            $display("FAIL mid_reset_load: err=%b rdata=%h lat=%0d, want err=0 rdata=0badf00d lat=2", e_err, d, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] model [64];
        logic e_err, sw, tw; logic [31:0] d, a, wd, wa, wv, ra; int lat; exp_t e;
        for (int i = 0; i < 64; i++) begin
            model[i] = $urandom;
            ram[i] = model[i];
        end
        for (int i = 0; i < 64; i++) begin
            wa = 32'($urandom_range(0, 63)) << 2;
            wv = $urandom;
            model[wa[7:2]] = wv;
            xfer(1, 2'b10, 0, wa, wv, e_err, d, lat, sw, a, wd, tw);
            ra = (i % 2 == 0) ? wa : (32'($urandom_range(0, 63)) << 2);
            sbq.push_back('{1'b0, model[ra[7:2]], 2});
            xfer(0, 2'b10, 0, ra, 32'h0, e_err, d, lat, sw, a, wd, tw);
            e = sbq.pop_front();
            checks++;
            if (e_err !== e.err || d !== e.rdata || lat !== e.lat) begin
                errors++;
                $display("FAIL rand[%0d] @%h: err=%b rdata=%h lat=%0d, want err=0 rdata=%h lat=2",
                         i, ra, e_err, d, lat, e.rdata);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        test_reset();
        test_word();
        test_subword_store();
        test_loads();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
